// File: rtl/ps2_key_pkg.sv
// Shared constants and types for the PS/2 key mapper: prefix bytes, ignore set,
// prefix FSM states, key map entry width and Pause sequence length.
package ps2_key_pkg;

  localparam logic [7:0] BYTE_EXT   = 8'hE0;
  localparam logic [7:0] BYTE_BRK   = 8'hF0;
  localparam logic [7:0] BYTE_PAUSE = 8'hE1;

  localparam int         MAP_W      = 9;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } prefix_state_e;

  // Keyboard status/ack bytes that never represent a key while idle.
  function automatic logic is_ignored(input logic [7:0] b);
    return b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  endfunction

endpackage

// File: rtl/ps2_repeat_timer.sv
// Per-channel autorepeat counter: loaded with the initial delay on press,
// reloaded with the period on every expiry, cleared on release.
module ps2_repeat_timer #(
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_start,
  input  logic i_stop,
  input  logic i_held,
  output logic o_repeat
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] DELAY_LD  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] PERIOD_LD = CW'(REPEAT_PERIOD);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  logic [CW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_stop) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= DELAY_LD;
    end else if (i_held && r_cnt == CNT_ONE) begin
      r_cnt <= PERIOD_LD;
    end else if (i_held && r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_ONE;
    end
  end

  // Expiry is flagged while the count sits at 1; the top registers it into
  // the press strobe one cycle later, which is exactly DELAY/PERIOD cycles.
  assign o_repeat = i_held && (r_cnt == CNT_ONE);

endmodule

// File: rtl/ps2_key_mapper.sv
// PS/2 scan-code decoder mapping make/break events onto NUM_KEYS channels.
// Define KEY_AUTOREPEAT_EN to build the per-channel internal repeat timers.
module ps2_key_mapper
  import ps2_key_pkg::*;
#(
  parameter int NUM_KEYS      = 4,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_scan_valid,
  input  logic [7:0]                i_scan_code,
  input  logic [MAP_W*NUM_KEYS-1:0] i_key_map,
  output logic [NUM_KEYS-1:0]       o_key_held,
  output logic [NUM_KEYS-1:0]       o_key_press,
  output logic [NUM_KEYS-1:0]       o_key_release,
  output logic                      o_any_held
);

  if (NUM_KEYS < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("ps2_key_mapper: NUM_KEYS, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  prefix_state_e       r_state;
  prefix_state_e       w_state_nxt;
  logic [2:0]          r_skip_cnt;
  logic [2:0]          w_skip_nxt;
  logic                w_evt_valid;
  logic                w_evt_ext;
  logic                w_evt_brk;

  logic [NUM_KEYS-1:0] r_key_held;
  logic [NUM_KEYS-1:0] r_key_press;
  logic [NUM_KEYS-1:0] r_key_release;
  logic [NUM_KEYS-1:0] w_match;
  logic [NUM_KEYS-1:0] w_make;
  logic [NUM_KEYS-1:0] w_brk;
  logic [NUM_KEYS-1:0] w_start;
  logic [NUM_KEYS-1:0] w_stop;
  logic [NUM_KEYS-1:0] w_press_nxt;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_skip_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_skip_cnt <= w_skip_nxt;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves a signal unassigned and infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_skip_nxt  = r_skip_cnt;
    w_evt_valid = 1'b0;
    w_evt_ext   = 1'b0;
    w_evt_brk   = 1'b0;
    if (i_scan_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (i_scan_code == BYTE_EXT) begin
            w_state_nxt = ST_EXT;
          end else if (i_scan_code == BYTE_BRK) begin
            w_state_nxt = ST_BRK;
          end else if (i_scan_code == BYTE_PAUSE) begin
            w_state_nxt = ST_SKIP;
            w_skip_nxt  = PAUSE_SKIP;
          end else if (!is_ignored(i_scan_code)) begin
            w_evt_valid = 1'b1;
          end
        end
        ST_EXT: begin
          if (i_scan_code == BYTE_BRK) begin
            w_state_nxt = ST_EXT_BRK;
          end else if (i_scan_code != BYTE_EXT) begin
            w_evt_valid = 1'b1;
            w_evt_ext   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_BRK: begin
          w_evt_valid = 1'b1;
          w_evt_brk   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        ST_EXT_BRK: begin
          w_evt_valid = 1'b1;
          w_evt_ext   = 1'b1;
          w_evt_brk   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
        ST_SKIP: begin
          w_skip_nxt = r_skip_cnt - 3'd1;
          if (r_skip_cnt <= 3'd1) begin
            w_skip_nxt  = '0;
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Every channel whose entry equals the completed event responds, so
  // duplicate map entries drive several channels together.
  always_comb begin
    w_match = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      w_match[k] = w_evt_valid &&
                   (i_key_map[MAP_W*k +: MAP_W] == {w_evt_ext, i_scan_code});
    end
  end

  assign w_make  = w_match & {NUM_KEYS{~w_evt_brk}};
  assign w_brk   = w_match & {NUM_KEYS{w_evt_brk}};
  assign w_start = w_make & ~r_key_held;
  assign w_stop  = w_brk & r_key_held;

`ifdef KEY_AUTOREPEAT_EN
  logic [NUM_KEYS-1:0] w_repeat;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_timer
    ps2_repeat_timer #(
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
    ) u_timer (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_start  (w_start[k]),
      .i_stop   (w_stop[k]),
      .i_held   (r_key_held[k]),
      .o_repeat (w_repeat[k])
    );
  end

  // Keyboard typematic makes are dropped; a release beats a coincident expiry.
  assign w_press_nxt = w_start | (w_repeat & ~w_stop);
`else
  assign w_press_nxt = w_make;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_key_held    <= '0;
      r_key_press   <= '0;
      r_key_release <= '0;
    end else begin
      r_key_held    <= (r_key_held | w_make) & ~w_brk;
      r_key_press   <= w_press_nxt;
      r_key_release <= w_stop;
    end
  end

  assign o_key_held    = r_key_held;
  assign o_key_press   = r_key_press;
  assign o_key_release = r_key_release;
  assign o_any_held    = |r_key_held;

endmodule
